// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Shared AXI3 encodings for the memory responder: response codes, burst types,
// the only supported beat size, the read/write FSM state types and the
// burst range/size classifier used by both address channels.
// -----------------------------------------------------------------------------
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_8B = 3'b011;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  // Classify a burst. The end address is formed in 33 bits so a start near
  // the top of the 4 GiB space cannot wrap back into range. DECERR takes
  // precedence over a bad beat size.
  function automatic logic [1:0] burst_resp(input logic [31:0] addr,
                                            input logic [3:0]  len,
                                            input logic [2:0]  size,
                                            input logic [31:0] base,
                                            input logic [32:0] limit);
    logic [32:0] end_addr;
    logic [1:0]  resp;
    end_addr = {1'b0, addr} + {25'd0, ({1'b0, len} + 5'd1), 3'd0};
    if ((addr < base) || (end_addr > limit)) begin
      resp = RESP_DECERR;
    end else if (size != SIZE_8B) begin
      resp = RESP_SLVERR;
    end else begin
      resp = RESP_OKAY;
    end
    return resp;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// -----------------------------------------------------------------------------
// sdp_ram
// Simple dual-port RAM: one byte-enabled write port, one registered read
// port. A read and a write to the same word in one cycle return the old word.
// No reset on the array or the read register so the array maps onto BRAM.
// Ports:
//   clk_i    clock
//   i_we     write enable; i_be gates each byte lane of i_wdata
//   i_waddr  write word address
//   i_re     read enable; o_rdata holds its value while i_re is low
//   i_raddr  read word address
//   o_rdata  read data, valid the cycle after i_re
// -----------------------------------------------------------------------------
module sdp_ram #(
  parameter int DEPTH = 4096,
  parameter int WIDTH = 64
) (
  input  logic                     clk_i,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [WIDTH/8-1:0]       i_be,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Byte-enabled write port
  always_ff @(posedge clk_i) begin
    if (i_we) begin
      for (int k = 0; k < WIDTH / 8; k++) begin
        if (i_be[k]) begin
          r_mem[i_waddr][k*8 +: 8] <= i_wdata[k*8 +: 8];
        end
      end
    end
  end

  // Registered read port; nonblocking update gives read-first behaviour
  always_ff @(posedge clk_i) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_mem_responder.sv
// -----------------------------------------------------------------------------
// axi_mem_responder
// AXI3 slave backed by on-chip RAM. Serves INCR bursts of 64-bit beats; one
// read burst and one write burst may be active at the same time.
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   s_axi_ar* / s_axi_r*    read address and read data channels
//   s_axi_aw* / s_axi_w*    write address and write data channels
//   s_axi_b*                write response channel
// All handshake outputs come straight from flops.
// -----------------------------------------------------------------------------
module axi_mem_responder
  import axi_pkg::*;
#(
  parameter logic [31:0] BASE      = 32'h2000_0000,
  parameter int          MEM_WORDS = 4096,
  parameter int          ID_W      = 6
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [31:0]     s_axi_araddr,
  input  logic [3:0]      s_axi_arlen,
  input  logic [2:0]      s_axi_arsize,
  input  logic [1:0]      s_axi_arburst,
  input  logic [ID_W-1:0] s_axi_arid,
  input  logic            s_axi_arvalid,
  output logic            s_axi_arready,
  output logic [63:0]     s_axi_rdata,
  output logic [ID_W-1:0] s_axi_rid,
  output logic [1:0]      s_axi_rresp,
  output logic            s_axi_rlast,
  output logic            s_axi_rvalid,
  input  logic            s_axi_rready,
  input  logic [31:0]     s_axi_awaddr,
  input  logic [3:0]      s_axi_awlen,
  input  logic [2:0]      s_axi_awsize,
  input  logic [1:0]      s_axi_awburst,
  input  logic [ID_W-1:0] s_axi_awid,
  input  logic            s_axi_awvalid,
  output logic            s_axi_awready,
  input  logic [63:0]     s_axi_wdata,
  input  logic [7:0]      s_axi_wstrb,
  input  logic [ID_W-1:0] s_axi_wid,
  input  logic            s_axi_wlast,
  input  logic            s_axi_wvalid,
  output logic            s_axi_wready,
  output logic [ID_W-1:0] s_axi_bid,
  output logic [1:0]      s_axi_bresp,
  output logic            s_axi_bvalid,
  input  logic            s_axi_bready
);

  localparam int              AW      = $clog2(MEM_WORDS);
  localparam logic [32:0]     LIMIT   = {1'b0, BASE} + 33'(MEM_WORDS) * 33'd8;
  localparam logic [AW-1:0]   IDX_ONE = {{(AW-1){1'b0}}, 1'b1};

  // Address decode: word index is the byte offset from BASE, modulo the RAM.
  logic [31:0] w_ar_off;
  logic [31:0] w_aw_off;
  assign w_ar_off = s_axi_araddr - BASE;
  assign w_aw_off = s_axi_awaddr - BASE;

  // Burst type is ignored (everything is INCR); low/high offset bits unused.
  logic w_unused;
  assign w_unused = ^{s_axi_arburst, s_axi_awburst,
                      w_ar_off[31:AW+3], w_ar_off[2:0],
                      w_aw_off[31:AW+3], w_aw_off[2:0]};

  // ---------------------------------------------------------------- read side
  rd_state_e       r_rstate, w_rstate_nxt;
  logic [AW-1:0]   r_ridx, w_ridx_nxt;
  logic [3:0]      r_rlen, w_rlen_nxt;
  logic [3:0]      r_rcnt, w_rcnt_nxt;
  logic [ID_W-1:0] r_rid, w_rid_nxt;
  logic [1:0]      r_rresp, w_rresp_nxt;
  logic            r_rden, w_rden_nxt;
  logic            r_arready, r_rvalid, r_rlast;
  logic            w_ar_hs, w_r_hs;
  logic            w_ram_re;
  logic [AW-1:0]   w_ram_raddr;
  logic [63:0]     w_ram_rdata;

  assign w_ar_hs = s_axi_arvalid && r_arready;
  assign w_r_hs  = r_rvalid && s_axi_rready;

  // Read FSM next state, burst bookkeeping and RAM read request
  always_comb begin
    w_rstate_nxt = r_rstate;
    w_ridx_nxt   = r_ridx;
    w_rlen_nxt   = r_rlen;
    w_rcnt_nxt   = r_rcnt;
    w_rid_nxt    = r_rid;
    w_rresp_nxt  = r_rresp;
    w_rden_nxt   = r_rden;
    w_ram_re     = 1'b0;
    w_ram_raddr  = r_ridx;
    case (r_rstate)
      R_IDLE: begin
        if (w_ar_hs) begin
          w_ridx_nxt   = w_ar_off[AW+2:3];
          w_rlen_nxt   = s_axi_arlen;
          w_rcnt_nxt   = 4'd0;
          w_rid_nxt    = s_axi_arid;
          w_rresp_nxt  = burst_resp(s_axi_araddr, s_axi_arlen, s_axi_arsize, BASE, LIMIT);
          w_rden_nxt   = (w_rresp_nxt != RESP_DECERR);
          w_rstate_nxt = R_FETCH;
        end else begin
          w_rstate_nxt = R_IDLE;
        end
      end
      R_FETCH: begin
        w_ram_re     = 1'b1;
        w_rstate_nxt = R_DATA;
      end
      R_DATA: begin
        // Fetch the following word on the accepting edge so beats stream.
        if (w_r_hs) begin
          w_ram_re    = 1'b1;
          w_ram_raddr = r_ridx + IDX_ONE;
          w_ridx_nxt  = r_ridx + IDX_ONE;
          w_rcnt_nxt  = r_rcnt + 4'd1;
          if (r_rcnt == r_rlen) begin
            w_rstate_nxt = R_IDLE;
          end else begin
            w_rstate_nxt = R_DATA;
          end
        end else begin
          w_rstate_nxt = R_DATA;
        end
      end
      default: begin
        w_rstate_nxt = R_IDLE;
      end
    endcase
  end

  // Read FSM state, burst registers and registered R/AR handshake outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rstate  <= R_IDLE;
      r_ridx    <= '0;
      r_rlen    <= 4'd0;
      r_rcnt    <= 4'd0;
      r_rid     <= '0;
      r_rresp   <= RESP_OKAY;
      r_rden    <= 1'b0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_ridx    <= w_ridx_nxt;
      r_rlen    <= w_rlen_nxt;
      r_rcnt    <= w_rcnt_nxt;
      r_rid     <= w_rid_nxt;
      r_rresp   <= w_rresp_nxt;
      r_rden    <= w_rden_nxt;
      r_arready <= (w_rstate_nxt == R_IDLE);
      r_rvalid  <= (w_rstate_nxt == R_DATA);
      r_rlast   <= (w_rstate_nxt == R_DATA) && (w_rcnt_nxt == w_rlen_nxt);
    end
  end

  // --------------------------------------------------------------- write side
  wr_state_e       r_wstate, w_wstate_nxt;
  logic [AW-1:0]   r_widx, w_widx_nxt;
  logic [3:0]      r_wlen, w_wlen_nxt;
  logic [3:0]      r_wcnt, w_wcnt_nxt;
  logic [ID_W-1:0] r_wid, w_wid_nxt;
  logic [1:0]      r_wresp, w_wresp_nxt;
  logic            r_awready, r_wready, r_bvalid;
  logic            w_aw_hs, w_w_hs;
  logic            w_ram_we;

  assign w_aw_hs = s_axi_awvalid && r_awready;
  assign w_w_hs  = s_axi_wvalid && r_wready;

  // Write FSM next state, beat counting, sticky error and RAM write enable
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_widx_nxt   = r_widx;
    w_wlen_nxt   = r_wlen;
    w_wcnt_nxt   = r_wcnt;
    w_wid_nxt    = r_wid;
    w_wresp_nxt  = r_wresp;
    w_ram_we     = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs) begin
          w_widx_nxt   = w_aw_off[AW+2:3];
          w_wlen_nxt   = s_axi_awlen;
          w_wcnt_nxt   = 4'd0;
          w_wid_nxt    = s_axi_awid;
          w_wresp_nxt  = burst_resp(s_axi_awaddr, s_axi_awlen, s_axi_awsize, BASE, LIMIT);
          w_wstate_nxt = W_DATA;
        end else begin
          w_wstate_nxt = W_IDLE;
        end
      end
      W_DATA: begin
        if (w_w_hs) begin
          // Out-of-range bursts are drained but never reach the RAM.
          w_ram_we   = (r_wresp != RESP_DECERR);
          w_widx_nxt = r_widx + IDX_ONE;
          w_wcnt_nxt = r_wcnt + 4'd1;
          if ((r_wresp != RESP_DECERR) &&
              ((s_axi_wlast != (r_wcnt == r_wlen)) || (s_axi_wid != r_wid))) begin
            w_wresp_nxt = RESP_SLVERR;
          end else begin
            w_wresp_nxt = r_wresp;
          end
          // Beat count, not wlast, decides where the burst ends.
          if (r_wcnt == r_wlen) begin
            w_wstate_nxt = W_RESP;
          end else begin
            w_wstate_nxt = W_DATA;
          end
        end else begin
          w_wstate_nxt = W_DATA;
        end
      end
      W_RESP: begin
        if (r_bvalid && s_axi_bready) begin
          w_wstate_nxt = W_IDLE;
        end else begin
          w_wstate_nxt = W_RESP;
        end
      end
      default: begin
        w_wstate_nxt = W_IDLE;
      end
    endcase
  end

  // Write FSM state, burst registers and registered AW/W/B handshake outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wstate  <= W_IDLE;
      r_widx    <= '0;
      r_wlen    <= 4'd0;
      r_wcnt    <= 4'd0;
      r_wid     <= '0;
      r_wresp   <= RESP_OKAY;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_widx    <= w_widx_nxt;
      r_wlen    <= w_wlen_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_wid     <= w_wid_nxt;
      r_wresp   <= w_wresp_nxt;
      r_awready <= (w_wstate_nxt == W_IDLE);
      r_wready  <= (w_wstate_nxt == W_DATA);
      r_bvalid  <= (w_wstate_nxt == W_RESP);
    end
  end

  // -------------------------------------------------------------------- RAM
  sdp_ram #(
    .DEPTH (MEM_WORDS),
    .WIDTH (64)
  ) u_ram (
    .clk_i   (clk_i),
    .i_we    (w_ram_we),
    .i_waddr (r_widx),
    .i_wdata (s_axi_wdata),
    .i_be    (s_axi_wstrb),
    .i_re    (w_ram_re),
    .i_raddr (w_ram_raddr),
    .o_rdata (w_ram_rdata)
  );

  // ---------------------------------------------------------------- outputs
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rlast   = r_rlast;
  assign s_axi_rid     = r_rid;
  assign s_axi_rresp   = r_rresp;
  // Zero during reset and for out-of-range bursts; RAM output is unreset.
  assign s_axi_rdata   = w_ram_rdata & {64{r_rden}};
  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bid     = r_wid;
  assign s_axi_bresp   = r_wresp;

endmodule

// File: tb/tb_axi_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_axi_mem_responder
// Directed bench for axi_mem_responder: write/readback, stalled reads,
// out-of-range bursts, byte strobes, protocol errors and mid-burst reset.
// -----------------------------------------------------------------------------
module tb_axi_mem_responder;

  localparam int          ID_W = 6;
  localparam logic [31:0] BASE = 32'h2000_0000;

  logic            clk_i;
  logic            rst_ni;
  logic [31:0]     s_axi_araddr;
  logic [3:0]      s_axi_arlen;
  logic [2:0]      s_axi_arsize;
  logic [1:0]      s_axi_arburst;
  logic [ID_W-1:0] s_axi_arid;
  logic            s_axi_arvalid;
  logic            s_axi_arready;
  logic [63:0]     s_axi_rdata;
  logic [ID_W-1:0] s_axi_rid;
  logic [1:0]      s_axi_rresp;
  logic            s_axi_rlast;
  logic            s_axi_rvalid;
  logic            s_axi_rready;
  logic [31:0]     s_axi_awaddr;
  logic [3:0]      s_axi_awlen;
  logic [2:0]      s_axi_awsize;
  logic [1:0]      s_axi_awburst;
  logic [ID_W-1:0] s_axi_awid;
  logic            s_axi_awvalid;
  logic            s_axi_awready;
  logic [63:0]     s_axi_wdata;
  logic [7:0]      s_axi_wstrb;
  logic [ID_W-1:0] s_axi_wid;
  logic            s_axi_wlast;
  logic            s_axi_wvalid;
  logic            s_axi_wready;
  logic [ID_W-1:0] s_axi_bid;
  logic [1:0]      s_axi_bresp;
  logic            s_axi_bvalid;
  logic            s_axi_bready;

  axi_mem_responder dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
    .s_axi_arburst(s_axi_arburst), .s_axi_arid(s_axi_arid), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rid(s_axi_rid),
    .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awid(s_axi_awid),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb), .s_axi_wid(s_axi_wid), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bid(s_axi_bid),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0]     rd_data [16];
  logic [1:0]      rd_resp [16];
  logic            rd_last [16];
  logic [ID_W-1:0] rd_id;
  int              rd_n;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one write burst with AW and W valid together, then take the B response.
  task automatic write_burst(input logic [31:0] addr, input logic [3:0] len,
                             input logic [ID_W-1:0] id, input logic [ID_W-1:0] wid,
                             input logic [63:0] dbase, input logic [7:0] strb,
                             input int last_beat, output logic [1:0] bresp,
                             output logic [ID_W-1:0] bid, output int nbeats);
    bit aw_done;
    bit aw_fire;
    bit w_fire;
    int cyc;
    nbeats  = 0;
    aw_done = 1'b0;
    cyc     = 0;
    @(negedge clk_i);
    s_axi_awaddr  = addr;
    s_axi_awlen   = len;
    s_axi_awsize  = 3'd3;
    s_axi_awburst = 2'b01;
    s_axi_awid    = id;
    s_axi_awvalid = 1'b1;
    s_axi_wdata   = dbase;
    s_axi_wstrb   = strb;
    s_axi_wid     = wid;
    s_axi_wlast   = (last_beat == 0);
    s_axi_wvalid  = 1'b1;
    while ((!aw_done || nbeats <= int'(len)) && cyc < 200) begin
      aw_fire = s_axi_awvalid && s_axi_awready;
      w_fire  = s_axi_wvalid && s_axi_wready;
      @(negedge clk_i);
      cyc++;
      if (aw_fire) begin
        aw_done       = 1'b1;
        s_axi_awvalid = 1'b0;
      end
      if (w_fire) begin
        nbeats++;
        s_axi_wdata  = dbase + 64'(nbeats);
        s_axi_wlast  = (nbeats == last_beat);
        s_axi_wvalid = (nbeats <= int'(len));
      end
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    check_eq("aw_accepted", 64'(aw_done), 64'd1);
    s_axi_bready = 1'b1;
    cyc = 0;
    while (!s_axi_bvalid && cyc < 50) begin
      @(negedge clk_i);
      cyc++;
    end
    check_eq("bvalid_seen", 64'(s_axi_bvalid), 64'd1);
    bresp = s_axi_bresp;
    bid   = s_axi_bid;
    @(negedge clk_i);
    s_axi_bready = 1'b0;
    check_eq("bvalid_drop", 64'(s_axi_bvalid), 64'd0);
  endtask

  // Issue one read burst and collect its beats into rd_*; optionally stall on
  // alternate cycles, or pulse reset while beat abort_beat is presented.
  task automatic read_burst(input logic [31:0] addr, input logic [3:0] len,
                            input logic [ID_W-1:0] id, input logic [2:0] size,
                            input bit toggle, input int abort_beat);
    bit          fired;
    int          cyc;
    int          lat;
    int          span;
    bit          stalled;
    logic [63:0] s_data;
    logic        s_last;
    rd_n = 0;
    @(negedge clk_i);
    s_axi_araddr  = addr;
    s_axi_arlen   = len;
    s_axi_arsize  = size;
    s_axi_arburst = 2'b01;
    s_axi_arid    = id;
    s_axi_arvalid = 1'b1;
    fired = 1'b0;
    cyc   = 0;
    while (!fired && cyc < 50) begin
      fired = s_axi_arvalid && s_axi_arready;
      @(negedge clk_i);
      cyc++;
    end
    s_axi_arvalid = 1'b0;
    check_eq("ar_accepted", 64'(fired), 64'd1);
    lat = 1;
    while (!s_axi_rvalid && lat < 10) begin
      @(negedge clk_i);
      lat++;
    end
    check_eq("r_latency", 64'(lat), 64'd2);
    span    = 0;
    stalled = 1'b0;
    s_data  = 64'd0;
    s_last  = 1'b0;
    cyc     = 0;
    while (rd_n < int'(len) + 1 && cyc < 200) begin
      if (abort_beat >= 0 && rd_n == abort_beat && s_axi_rvalid) begin
        rst_ni = 1'b0;
        #1;
        check_eq("rvalid_in_reset", 64'(s_axi_rvalid), 64'd0);
        s_axi_rready = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_eq("arready_after_reset", 64'(s_axi_arready), 64'd1);
        return;
      end
      if (stalled) begin
        check_eq("stall_valid", 64'(s_axi_rvalid), 64'd1);
        check_eq("stall_data", s_axi_rdata, s_data);
        check_eq("stall_last", 64'(s_axi_rlast), 64'(s_last));
      end
      s_axi_rready = toggle ? ((cyc % 2) == 1) : 1'b1;
      stalled = s_axi_rvalid && !s_axi_rready;
      s_data  = s_axi_rdata;
      s_last  = s_axi_rlast;
      if (s_axi_rvalid && s_axi_rready) begin
        rd_data[rd_n] = s_axi_rdata;
        rd_resp[rd_n] = s_axi_rresp;
        rd_last[rd_n] = s_axi_rlast;
        rd_id         = s_axi_rid;
        rd_n++;
      end
      @(negedge clk_i);
      cyc++;
      span++;
    end
    s_axi_rready = 1'b0;
    check_eq("r_beats", 64'(rd_n), 64'(int'(len) + 1));
    check_eq("r_no_extra", 64'(s_axi_rvalid), 64'd0);
    check_eq("arready_after_burst", 64'(s_axi_arready), 64'd1);
    if (!toggle) begin
      check_eq("r_back_to_back", 64'(span), 64'(int'(len) + 1));
    end
  endtask

  // Compare collected beats against base+i (or zero), a fixed resp and id.
  task automatic check_read(input string tag, input int len, input logic [63:0] dbase,
                            input bit zero, input logic [1:0] resp, input logic [ID_W-1:0] id);
    check_eq({tag, "_rid"}, 64'(rd_id), 64'(id));
    for (int i = 0; i <= len && i < rd_n; i++) begin
      check_eq($sformatf("%s_data%0d", tag, i), rd_data[i], zero ? 64'd0 : dbase + 64'(i));
      check_eq($sformatf("%s_resp%0d", tag, i), 64'(rd_resp[i]), 64'(resp));
      check_eq($sformatf("%s_last%0d", tag, i), 64'(rd_last[i]), 64'(i == len));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]      bresp;
    logic [ID_W-1:0] bid;
    int              nb;

    rst_ni = 1'b1;
    s_axi_araddr = 32'd0; s_axi_arlen = 4'd0; s_axi_arsize = 3'd0; s_axi_arburst = 2'd0;
    s_axi_arid = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    s_axi_awaddr = 32'd0; s_axi_awlen = 4'd0; s_axi_awsize = 3'd0; s_axi_awburst = 2'd0;
    s_axi_awid = '0; s_axi_awvalid = 1'b0; s_axi_wdata = 64'd0; s_axi_wstrb = 8'd0;
    s_axi_wid = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    #1 rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);

    // Reset state
    check_eq("rst_arready", 64'(s_axi_arready), 64'd0);
    check_eq("rst_awready", 64'(s_axi_awready), 64'd0);
    check_eq("rst_wready",  64'(s_axi_wready),  64'd0);
    check_eq("rst_rvalid",  64'(s_axi_rvalid),  64'd0);
    check_eq("rst_bvalid",  64'(s_axi_bvalid),  64'd0);
    check_eq("rst_rdata",   s_axi_rdata,        64'd0);
    check_eq("rst_rid",     64'(s_axi_rid),     64'd0);
    check_eq("rst_rresp",   64'(s_axi_rresp),   64'd0);
    check_eq("rst_bid",     64'(s_axi_bid),     64'd0);
    check_eq("rst_bresp",   64'(s_axi_bresp),   64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_eq("idle_arready", 64'(s_axi_arready), 64'd1);
    check_eq("idle_awready", 64'(s_axi_awready), 64'd1);

    // Full burst write of 0..15 then readback
    write_burst(BASE, 4'd15, 6'h15, 6'h15, 64'd0, 8'hFF, 15, bresp, bid, nb);
    check_eq("wr0_bresp", 64'(bresp), 64'd0);
    check_eq("wr0_bid", 64'(bid), 64'h15);
    check_eq("wr0_beats", 64'(nb), 64'd16);
    read_burst(BASE, 4'd15, 6'h2A, 3'd3, 1'b0, -1);
    check_read("rd0", 15, 64'd0, 1'b0, 2'b00, 6'h2A);

    // Stalled read with rready toggling
    read_burst(BASE, 4'd15, 6'h01, 3'd3, 1'b1, -1);
    check_read("rdtog", 15, 64'd0, 1'b0, 2'b00, 6'h01);

    // Byte strobes over a preloaded all-ones word
    write_burst(BASE + 32'h100, 4'd0, 6'h03, 6'h03, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, bresp, bid, nb);
    check_eq("pre_bresp", 64'(bresp), 64'd0);
    write_burst(BASE + 32'h100, 4'd0, 6'h03, 6'h03, 64'h1234_5678_9ABC_DEF0, 8'h0F, 0, bresp, bid, nb);
    check_eq("strb_bresp", 64'(bresp), 64'd0);
    read_burst(BASE + 32'h100, 4'd0, 6'h04, 3'd3, 1'b0, -1);
    check_read("strb", 0, 64'hFFFF_FFFF_9ABC_DEF0, 1'b0, 2'b00, 6'h04);

    // Burst crossing the end of RAM: preload the last 8 words, then DECERR write
    write_burst(BASE + 32'h7FC0, 4'd7, 6'h04, 6'h04, 64'hC0DE_0000_0000_0000, 8'hFF, 7, bresp, bid, nb);
    check_eq("tail_bresp", 64'(bresp), 64'd0);
    write_burst(BASE + 32'h7FC0, 4'd15, 6'h05, 6'h05, 64'hDEAD_0000_0000_0000, 8'hFF, 15, bresp, bid, nb);
    check_eq("oor_bresp", 64'(bresp), 64'd3);
    check_eq("oor_bid", 64'(bid), 64'h05);
    check_eq("oor_beats", 64'(nb), 64'd16);
    read_burst(BASE + 32'h7FC0, 4'd7, 6'h06, 3'd3, 1'b0, -1);
    check_read("tail", 7, 64'hC0DE_0000_0000_0000, 1'b0, 2'b00, 6'h06);
    read_burst(BASE, 4'd15, 6'h06, 3'd3, 1'b0, -1);
    check_read("head", 15, 64'd0, 1'b0, 2'b00, 6'h06);
    read_burst(BASE + 32'h7FC0, 4'd15, 6'h07, 3'd3, 1'b0, -1);
    check_read("oor_rd", 15, 64'd0, 1'b1, 2'b11, 6'h07);

    // Early wlast: all 16 beats still taken, SLVERR, data written
    write_burst(BASE + 32'h200, 4'd15, 6'h08, 6'h08, 64'h0000_7700_0000_0000, 8'hFF, 7, bresp, bid, nb);
    check_eq("wlast_bresp", 64'(bresp), 64'd2);
    check_eq("wlast_beats", 64'(nb), 64'd16);
    read_burst(BASE + 32'h200, 4'd15, 6'h09, 3'd3, 1'b0, -1);
    check_read("wlast_rd", 15, 64'h0000_7700_0000_0000, 1'b0, 2'b00, 6'h09);

    // WID differs from AWID: SLVERR
    write_burst(BASE + 32'h300, 4'd1, 6'h09, 6'h0A, 64'h55, 8'hFF, 1, bresp, bid, nb);
    check_eq("wid_bresp", 64'(bresp), 64'd2);
    check_eq("wid_bid", 64'(bid), 64'h09);

    // arsize=2: SLVERR on every beat, data still moves
    read_burst(BASE, 4'd15, 6'h0B, 3'd2, 1'b0, -1);
    check_read("size2", 15, 64'd0, 1'b0, 2'b10, 6'h0B);

    // Reset during beat 5, then a fresh full read
    read_burst(BASE, 4'd15, 6'h0C, 3'd3, 1'b0, 5);
    read_burst(BASE, 4'd15, 6'h0D, 3'd3, 1'b0, -1);
    check_read("post_rst", 15, 64'd0, 1'b0, 2'b00, 6'h0D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
